// File: rtl/ula_muldiv_seq_if.sv
// ula_muldiv_seq_if: request/response bundle of the sequential RV32M multiply/divide unit.
// The master side issues requests and consumes results; the slave side is the unit itself.
// Signal prefixes follow the unit's point of view: i* flows into the unit, o* flows out of it.
interface ula_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            iValid;
    logic            oReady;
    logic [6:0]      iOpcode;
    logic [2:0]      iFunct3;
    logic [6:0]      iFunct7;
    logic [XLEN-1:0] iA;
    logic [XLEN-1:0] iB;
    logic            oValid;
    logic            iReady;
    logic [XLEN-1:0] oResult;
    logic            oIllegal;

    modport master (
        output iValid, iOpcode, iFunct3, iFunct7, iA, iB, iReady,
        input  oReady, oValid, oResult, oIllegal
    );

    modport slave (
        input  iValid, iOpcode, iFunct3, iFunct7, iA, iB, iReady,
        output oReady, oValid, oResult, oIllegal
    );
endinterface

// File: rtl/ula_muldiv_seq.sv
// ula_muldiv_seq: sequential RV32M multiply/divide unit for the ULA datapath.
// Multiply is radix-2 shift-add on operand magnitudes; divide is restoring, one bit per cycle.
// Signs are fixed up in a single FIX cycle. Divide-by-zero and signed overflow bypass the
// iterative loop entirely. Non-M requests complete one cycle after accept with oIllegal set.
// Optional feature: define MULDIV_EARLY_OUT_EN to let a multiply leave RUN as soon as the
// remaining multiplier bits are all zero; the product is re-aligned in FIX.
module ula_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic iCLK,
    input  logic iRST,
    ula_muldiv_seq_if.slave bus
);

    localparam int CNTW = $clog2(XLEN) + 1;

    localparam logic [6:0] OPC_OP = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t            state;
    logic [2:0]        funct3Q;
    logic              bypassQ;
    logic              negProdQ;
    logic              negQuotQ;
    logic              negRemQ;
    logic [XLEN-1:0]   operandQ;
    logic [2*XLEN-1:0] prodQ;
    logic [CNTW-1:0]   cntQ;

    logic              isMop;
    logic              isDivReq;
    logic              signedA;
    logic              signedB;
    logic              aNeg;
    logic              bNeg;
    logic [XLEN-1:0]   absA;
    logic [XLEN-1:0]   absB;
    logic              divZero;
    logic              divOverflow;
    logic [XLEN-1:0]   specialVal;

    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     divTrial;
    logic [2*XLEN-1:0] stepNext;

    logic [2*XLEN-1:0] alignedProd;
    logic [2*XLEN-1:0] signedProd;
    logic [XLEN-1:0]   quotAbs;
    logic [XLEN-1:0]   remAbs;
    logic [XLEN-1:0]   fixResult;

    // Request decode: M-op detection, operand magnitudes and the two bypass special cases
    always_comb begin
        isMop       = (bus.iOpcode == OPC_OP) && (bus.iFunct7 == F7_MULDIV);
        isDivReq    = bus.iFunct3[2];
        aNeg        = bus.iA[XLEN-1];
        bNeg        = bus.iB[XLEN-1];
        signedA     = isDivReq ? ~bus.iFunct3[0] : (bus.iFunct3 != 3'b011);
        signedB     = isDivReq ? ~bus.iFunct3[0] : ~bus.iFunct3[1];
        absA        = (signedA && aNeg) ? (~bus.iA + 1'b1) : bus.iA;
        absB        = (signedB && bNeg) ? (~bus.iB + 1'b1) : bus.iB;
        divZero     = isDivReq && (bus.iB == '0);
        divOverflow = isDivReq && ~bus.iFunct3[0]
                      && (bus.iA == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.iB == {XLEN{1'b1}});
        specialVal  = '0;
        if (divZero) begin
            specialVal = bus.iFunct3[1] ? bus.iA : {XLEN{1'b1}};
        end else if (divOverflow) begin
            specialVal = bus.iFunct3[1] ? '0 : bus.iA;
        end
    end

    // One iteration of either shift-add multiply or restoring divide on the shared register
    always_comb begin
        mulSum   = {1'b0, prodQ[2*XLEN-1:XLEN]} + (prodQ[0] ? {1'b0, operandQ} : '0);
        divTrial = {prodQ[2*XLEN-1], prodQ[2*XLEN-2:XLEN-1]} - {1'b0, operandQ};
        if (funct3Q[2]) begin
            if (!divTrial[XLEN]) begin
                stepNext = {divTrial[XLEN-1:0], prodQ[XLEN-2:0], 1'b1};
            end else begin
                stepNext = {prodQ[2*XLEN-2:0], 1'b0};
            end
        end else begin
            stepNext = {mulSum, prodQ[XLEN-1:1]};
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic mulRestZero;

    // Early-out test: the multiplier bits still to be consumed sit in prodQ[cntQ-1:0]
    always_comb begin
        mulRestZero = 1'b1;
        for (int i = 0; i < XLEN; i++) begin
            if ((i < int'(cntQ)) && prodQ[i]) begin
                mulRestZero = 1'b0;
            end
        end
    end

    // Skipped iterations would only have shifted the product right, so do that shift here
    always_comb begin
        alignedProd = prodQ >> cntQ;
    end
`else
    // Fixed-latency build: the product is already aligned after all XLEN iterations
    always_comb begin
        alignedProd = prodQ;
    end
`endif

    // Sign correction and result selection used by the FIX state
    always_comb begin
        signedProd = negProdQ ? (~alignedProd + 1'b1) : alignedProd;
        quotAbs    = prodQ[XLEN-1:0];
        remAbs     = prodQ[2*XLEN-1:XLEN];
        fixResult  = '0;
        if (bypassQ) begin
            fixResult = prodQ[XLEN-1:0];
        end else begin
            case (funct3Q)
                3'b000:                 fixResult = signedProd[XLEN-1:0];
                3'b001, 3'b010, 3'b011: fixResult = signedProd[2*XLEN-1:XLEN];
                3'b100, 3'b101:         fixResult = negQuotQ ? (~quotAbs + 1'b1) : quotAbs;
                default:                fixResult = negRemQ ? (~remAbs + 1'b1) : remAbs;
            endcase
        end
    end

    // Control FSM with registered handshake outputs; reset aborts any operation in flight
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state        <= IDLE;
            funct3Q      <= '0;
            bypassQ      <= 1'b0;
            negProdQ     <= 1'b0;
            negQuotQ     <= 1'b0;
            negRemQ      <= 1'b0;
            operandQ     <= '0;
            prodQ        <= '0;
            cntQ         <= '0;
            bus.oReady   <= 1'b1;
            bus.oValid   <= 1'b0;
            bus.oResult  <= '0;
            bus.oIllegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iValid) begin
                        funct3Q    <= bus.iFunct3;
                        bus.oReady <= 1'b0;
                        if (!isMop) begin
                            state        <= DONE;
                            bus.oValid   <= 1'b1;
                            bus.oIllegal <= 1'b1;
                            bus.oResult  <= '0;
                        end else if (divZero || divOverflow) begin
                            state   <= FIX;
                            bypassQ <= 1'b1;
                            prodQ   <= {{XLEN{1'b0}}, specialVal};
                            cntQ    <= '0;
                        end else begin
                            state    <= RUN;
                            bypassQ  <= 1'b0;
                            cntQ     <= CNTW'(XLEN);
                            operandQ <= isDivReq ? absB : absA;
                            prodQ    <= {{XLEN{1'b0}}, (isDivReq ? absA : absB)};
                            negProdQ <= (signedA && aNeg) ^ (signedB && bNeg);
                            negQuotQ <= (signedA && aNeg) ^ (signedB && bNeg);
                            negRemQ  <= signedA && aNeg;
                        end
                    end
                end
                RUN: begin
`ifdef MULDIV_EARLY_OUT_EN
                    if (!funct3Q[2] && mulRestZero) begin
                        state <= FIX;
                    end else begin
                        prodQ <= stepNext;
                        cntQ  <= cntQ - 1'b1;
                        if (cntQ == CNTW'(1)) begin
                            state <= FIX;
                        end
                    end
`else
                    prodQ <= stepNext;
                    cntQ  <= cntQ - 1'b1;
                    if (cntQ == CNTW'(1)) begin
                        state <= FIX;
                    end
`endif
                end
                FIX: begin
                    state        <= DONE;
                    bus.oValid   <= 1'b1;
                    bus.oIllegal <= 1'b0;
                    bus.oResult  <= fixResult;
                end
                DONE: begin
                    if (bus.iReady) begin
                        state        <= IDLE;
                        bus.oValid   <= 1'b0;
                        bus.oIllegal <= 1'b0;
                        bus.oReady   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_muldiv_seq.sv
// tb_ula_muldiv_seq: directed self-checking bench for the sequential multiply/divide unit.
// Default (fixed-latency) build; every expected value is hand-computed.
module tb_ula_muldiv_seq;

    localparam int XLEN = 32;
    localparam logic [6:0] OPC_OP = 7'b0110011;
    localparam logic [6:0] F7_M = 7'b0000001;

    logic iCLK = 1'b0;
    logic iRST;

    int testsRun = 0;
    int testsFailed = 0;

    ula_muldiv_seq_if #(.XLEN(XLEN)) bus ();

    ula_muldiv_seq #(.XLEN(XLEN)) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .bus (bus)
    );

    // Free-running 10-unit clock
    always #5 iCLK = ~iCLK;

    // Issues one request (caller is #1 after an edge with oReady high) and waits for oValid.
    // lat counts cycles from the accepting edge; -1 means the wait expired.
    task automatic runOp(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ill, output int lat);
        bus.iOpcode = opc;
        bus.iFunct3 = f3;
        bus.iFunct7 = f7;
        bus.iA      = a;
        bus.iB      = b;
        bus.iValid  = 1'b1;
        @(posedge iCLK);
        #1;
        bus.iValid  = 1'b0;
        bus.iA      = 32'hA5A5_5A5A;
        bus.iB      = 32'h1234_5678;
        bus.iFunct3 = 3'b111;
        lat = 1;
        while (!bus.oValid && lat < 100) begin
            @(posedge iCLK);
            #1;
            lat++;
        end
        if (!bus.oValid) lat = -1;
        res = bus.oResult;
        ill = bus.oIllegal;
    endtask

    // Completes the DONE handshake in one cycle
    task automatic completeHandshake();
        bus.iReady = 1'b1;
        @(posedge iCLK);
        #1;
        bus.iReady = 1'b0;
    endtask

    task automatic test_reset();
        iRST = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        iRST = 1'b0;
        testsRun++;
        if (bus.oValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_oValid: got %b expected 0", bus.oValid); end
        testsRun++;
        if (bus.oResult !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_oResult: got %h expected 00000000", bus.oResult); end
        testsRun++;
        if (bus.oIllegal !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_oIllegal: got %b expected 0", bus.oIllegal); end
        testsRun++;
        if (bus.oReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_oReady: got %b expected 1", bus.oReady); end
    endtask

    task automatic test_mul();
        logic [31:0] res;
        logic ill;
        int lat;
        runOp(OPC_OP, 3'b000, F7_M, 32'd7, 32'hFFFF_FFFD, res, ill, lat);
        testsRun++;
        if (res !== 32'hFFFF_FFEB) begin testsFailed++; $display("[TB] FAIL mul_7x-3: got %h expected ffffffeb", res); end
        testsRun++;
        if (lat !== 34) begin testsFailed++; $display("[TB] FAIL mul_latency: got %0d expected 34", lat); end
        testsRun++;
        if (ill !== 1'b0) begin testsFailed++; $display("[TB] FAIL mul_illegal: got %b expected 0", ill); end
        completeHandshake();
        testsRun++;
        if (bus.oReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL mul_ready_after: got %b expected 1", bus.oReady); end
    endtask

    task automatic test_mulh();
        logic [2:0]  f3s [3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res;
        logic ill;
        int lat;
        for (int i = 0; i < 3; i++) begin
            runOp(OPC_OP, f3s[i], F7_M, as[i], bs[i], res, ill, lat);
            testsRun++;
            if (res !== exp[i]) begin testsFailed++; $display("[TB] FAIL mulh_%0d: got %h expected %h", i, res, exp[i]); end
            testsRun++;
            if (lat !== 34) begin testsFailed++; $display("[TB] FAIL mulh_latency_%0d: got %0d expected 34", i, lat); end
            completeHandshake();
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3s [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as  [4] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] bs  [4] = '{32'd7, 32'd7, 32'd2, 32'd2};
        logic [31:0] exp [4] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        logic [31:0] res;
        logic ill;
        int lat;
        for (int i = 0; i < 4; i++) begin
            runOp(OPC_OP, f3s[i], F7_M, as[i], bs[i], res, ill, lat);
            testsRun++;
            if (res !== exp[i]) begin testsFailed++; $display("[TB] FAIL div_%0d: got %h expected %h", i, res, exp[i]); end
            testsRun++;
            if (lat !== 34) begin testsFailed++; $display("[TB] FAIL div_latency_%0d: got %0d expected 34", i, lat); end
            completeHandshake();
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3s [6] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as  [6] = '{32'd123, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd9};
        logic [31:0] res;
        logic ill;
        int lat;
        for (int i = 0; i < 6; i++) begin
            runOp(OPC_OP, f3s[i], F7_M, as[i], bs[i], res, ill, lat);
            testsRun++;
            if (res !== exp[i]) begin testsFailed++; $display("[TB] FAIL special_%0d: got %h expected %h", i, res, exp[i]); end
            testsRun++;
            if (lat !== 2) begin testsFailed++; $display("[TB] FAIL special_latency_%0d: got %0d expected 2", i, lat); end
            completeHandshake();
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] res;
        logic ill;
        int lat;
        runOp(OPC_OP, 3'b000, F7_M, 32'd3, 32'd5, res, ill, lat);
        testsRun++;
        if (res !== 32'd15) begin testsFailed++; $display("[TB] FAIL bp_result: got %h expected 0000000f", res); end
        for (int i = 0; i < 10; i++) begin
            bus.iOpcode = OPC_OP;
            bus.iFunct7 = F7_M;
            bus.iFunct3 = 3'b000;
            bus.iA      = 32'd9;
            bus.iB      = 32'd9;
            bus.iValid  = (i % 3 == 0);
            @(posedge iCLK);
            #1;
            testsRun++;
            if (bus.oResult !== 32'd15) begin testsFailed++; $display("[TB] FAIL bp_hold_result_%0d: got %h expected 0000000f", i, bus.oResult); end
            testsRun++;
            if (bus.oReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_ready_low_%0d: got %b expected 0", i, bus.oReady); end
            testsRun++;
            if (bus.oValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_valid_high_%0d: got %b expected 1", i, bus.oValid); end
        end
        bus.iValid = 1'b0;
        completeHandshake();
        testsRun++;
        if (bus.oReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_ready_after: got %b expected 1", bus.oReady); end
        testsRun++;
        if (bus.oValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_valid_after: got %b expected 0", bus.oValid); end
    endtask

    task automatic test_reset_abort();
        int spurious;
        bus.iOpcode = OPC_OP;
        bus.iFunct7 = F7_M;
        bus.iFunct3 = 3'b100;
        bus.iA      = 32'd1000;
        bus.iB      = 32'd3;
        bus.iValid  = 1'b1;
        @(posedge iCLK);
        #1;
        bus.iValid = 1'b0;
        repeat (10) @(posedge iCLK);
        #1;
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        testsRun++;
        if (bus.oValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_oValid: got %b expected 0", bus.oValid); end
        testsRun++;
        if (bus.oResult !== 32'h0) begin testsFailed++; $display("[TB] FAIL abort_oResult: got %h expected 00000000", bus.oResult); end
        testsRun++;
        if (bus.oReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL abort_oReady: got %b expected 1", bus.oReady); end
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge iCLK);
            #1;
            if (bus.oValid) spurious++;
        end
        testsRun++;
        if (spurious !== 0) begin testsFailed++; $display("[TB] FAIL abort_no_partial: got %0d valid cycles expected 0", spurious); end
    endtask

    task automatic test_illegal();
        logic [31:0] res;
        logic ill;
        int lat;
        runOp(OPC_OP, 3'b000, 7'b0000000, 32'd11, 32'd22, res, ill, lat);
        testsRun++;
        if (ill !== 1'b1) begin testsFailed++; $display("[TB] FAIL illegal_flag: got %b expected 1", ill); end
        testsRun++;
        if (res !== 32'h0) begin testsFailed++; $display("[TB] FAIL illegal_result: got %h expected 00000000", res); end
        testsRun++;
        if (lat !== 1) begin testsFailed++; $display("[TB] FAIL illegal_latency: got %0d expected 1", lat); end
        completeHandshake();
        testsRun++;
        if (bus.oReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL illegal_ready_after: got %b expected 1", bus.oReady); end
    endtask

    // Scenario sequence
    initial begin
        iRST        = 1'b1;
        bus.iValid  = 1'b0;
        bus.iReady  = 1'b0;
        bus.iOpcode = '0;
        bus.iFunct3 = '0;
        bus.iFunct7 = '0;
        bus.iA      = '0;
        bus.iB      = '0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_back_pressure();
        test_reset_abort();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
